// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, transaction owner
// and the width of the optional starvation counter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   typedef enum logic {
      OWN_IF,
      OWN_D
   } arb_owner_t;

   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_if.sv
// Bundle of the fetch port, data port and single-ported memory port.
// slave = the arbiter's view, master = the pipeline/memory environment.
interface mem_arb_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_kill;
   logic              if_ready;
   logic [DATA_W-1:0] if_rdata;

   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      output if_ready, if_rdata, d_ready, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, if_kill, d_req, d_we, d_addr, d_wdata,
             mem_gnt, mem_rvalid, mem_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arb_starve_guard.sv
// Counts consecutive data grants taken while a fetch waits and forces the
// next arbitration to fetch once STARVE_MAX is reached.
module mem_arb_starve_guard
   import mem_arb_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle,
   input  logic if_req,
   input  logic d_req,
   output logic force_if
);

   logic [STARVE_CNT_W-1:0] cnt_q;

   assign force_if = if_req && (cnt_q == STARVE_CNT_W'(STARVE_MAX));

   // Any IDLE cycle that is not "data wins over a waiting fetch" restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (idle) begin
         if (!if_req || !d_req || force_if) cnt_q <= '0;
         else                               cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between IF and MEM stages, one transaction
// at a time, data first. Define MEM_ARB_STARVE_GUARD_EN to bound fetch starvation.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic     clk,
   input  logic     rst,
   mem_arb_if.slave bus,
   output logic     busy
);

   arb_state_t        state_q, state_d;
   arb_owner_t        owner_q;
   logic              we_q;
   logic              killed_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] if_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              grant_d;
   logic              grant_if;
   logic              force_if;
   logic              kill_now;
   logic              rsp_valid;

   if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_starve_max_range
      $error("mem_arbiter: STARVE_MAX must be within 1..15");
   end

`ifdef MEM_ARB_STARVE_GUARD_EN
   mem_arb_starve_guard #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve_guard (
      .clk      (clk),
      .rst      (rst),
      .idle     (state_q == IDLE),
      .if_req   (bus.if_req),
      .d_req    (bus.d_req),
      .force_if (force_if)
   );
`else
   assign force_if = 1'b0;
`endif

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d  = state_q;
      grant_d  = 1'b0;
      grant_if = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.d_req && !force_if) grant_d  = 1'b1;
            else if (bus.if_req)        grant_if = 1'b1;
            if (grant_d || grant_if)    state_d  = ISSUE;
         end
         ISSUE:   if (bus.mem_gnt)    state_d = WAIT;
         WAIT:    if (bus.mem_rvalid) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign kill_now  = bus.if_kill && (owner_q == OWN_IF) && (state_q != IDLE);
   assign rsp_valid = (state_q == WAIT) && bus.mem_rvalid;

   // NOTE: state is updated with <= so all flops see pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= OWN_IF;
         we_q       <= 1'b0;
         killed_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         if (grant_d || grant_if) begin
            owner_q <= grant_d ? OWN_D : OWN_IF;
            we_q    <= grant_d && bus.d_we;
            addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            wdata_q <= grant_d ? bus.d_wdata : '0;
         end
         if (state_d == IDLE) killed_q <= 1'b0;
         else if (kill_now)   killed_q <= 1'b1;
         // A kill arriving with the response still blocks the fetch data.
         if (rsp_valid && owner_q == OWN_D && !we_q)
            d_rdata_q <= bus.mem_rdata;
         if (rsp_valid && owner_q == OWN_IF && !killed_q && !bus.if_kill)
            if_rdata_q <= bus.mem_rdata;
      end
   end

   assign bus.mem_req   = (state_q == ISSUE);
   assign bus.mem_we    = (state_q == ISSUE) && we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.if_ready  = (state_q == RESP) && (owner_q == OWN_IF) && !killed_q;
   assign bus.d_ready   = (state_q == RESP) && (owner_q == OWN_D);
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences for
// simultaneous requests, kill, starvation and reset mid-transaction.
module tb_mem_arbiter;

   logic clk;
   logic rst;
   logic busy;

   mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W     (32),
      .DATA_W     (32),
      .STARVE_MAX (4)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- memory model ----------------
   int          gnt_dly;
   int          rv_dly;
   logic        gnt_m;
   logic        rv_m;
   logic        rv_extra;
   logic [31:0] rdata_m;
   logic [31:0] mem_arr [logic [31:0]];

   assign bus.mem_gnt    = gnt_m;
   assign bus.mem_rvalid = rv_m | rv_extra;
   assign bus.mem_rdata  = rdata_m;

   initial begin : mem_model
      int          phase;
      int          cnt;
      logic        we_l;
      logic [31:0] a_l;
      logic [31:0] wd_l;
      phase   = 0;
      cnt     = 0;
      gnt_m   = 1'b0;
      rv_m    = 1'b0;
      rdata_m = '0;
      forever begin
         @(negedge clk);
         #1;
         gnt_m = 1'b0;
         rv_m  = 1'b0;
         if (rst) begin
            phase = 0;
         end else begin
            if (phase == 0 && bus.mem_req) begin
               we_l  = bus.mem_we;
               a_l   = bus.mem_addr;
               wd_l  = bus.mem_wdata;
               cnt   = gnt_dly;
               phase = 1;
            end else if (phase == 2) begin
               if (cnt == 0) begin
                  rv_m = 1'b1;
                  if (we_l) begin
                     mem_arr[a_l] = wd_l;
                     rdata_m      = 32'hBAD0_0000;
                  end else begin
                     rdata_m = mem_arr.exists(a_l) ? mem_arr[a_l] : 32'h0;
                  end
                  phase = 0;
               end else begin
                  cnt--;
               end
            end
            if (phase == 1) begin
               if (cnt == 0) begin
                  gnt_m = 1'b1;
                  cnt   = rv_dly;
                  phase = 2;
               end else begin
                  cnt--;
               end
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } sb_t;

   sb_t sb_q[$];

   task automatic sb_push(input bit is_d, input logic [31:0] data);
      sb_t e;
      e.is_d = is_d;
      e.data = data;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input bit is_d, input logic [31:0] data);
      sb_t e;
      if (sb_q.size() == 0) begin
         check(is_d ? "sb_unexpected_d_ready" : "sb_unexpected_if_ready", sb_q.size(), 1);
      end else begin
         e = sb_q.pop_front();
         check("sb_port", is_d, e.is_d);
         check(is_d ? "sb_d_rdata" : "sb_if_rdata", data, e.data);
      end
   endtask

   always @(negedge clk) begin
      if (bus.d_ready)  sb_check(1'b1, bus.d_rdata);
      if (bus.if_ready) sb_check(1'b0, bus.if_rdata);
   end

   // ---------------- helpers ----------------
   task automatic check_outputs_zero(input string tag);
      check({tag, "_mem_req"},   bus.mem_req,   0);
      check({tag, "_mem_we"},    bus.mem_we,    0);
      check({tag, "_mem_addr"},  bus.mem_addr,  0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      check({tag, "_if_ready"},  bus.if_ready,  0);
      check({tag, "_d_ready"},   bus.d_ready,   0);
      check({tag, "_if_rdata"},  bus.if_rdata,  0);
      check({tag, "_d_rdata"},   bus.d_rdata,   0);
      check({tag, "_busy"},      busy,          0);
   endtask

   // One transaction from request to ready; kill_at pulses if_kill at that cycle (0 = never).
   task automatic run_xact(input string tag, input bit is_d, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int gdly, input int rdly, input int kill_at,
                           input logic [31:0] exp_data);
      int lat;
      bit seen;
      gnt_dly = gdly;
      rv_dly  = rdly;
      if (is_d) begin
         bus.d_req   = 1'b1;
         bus.d_we    = we;
         bus.d_addr  = addr;
         bus.d_wdata = wdata;
      end else begin
         bus.if_req  = 1'b1;
         bus.if_addr = addr;
      end
      sb_push(is_d, exp_data);
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 60) begin
         @(negedge clk);
         lat++;
         bus.if_kill = (kill_at != 0) && (lat == kill_at);
         if (lat == 1) check({tag, "_mem_req_n1"}, bus.mem_req, 1);
         if (bus.mem_req) begin
            check({tag, "_mem_addr"}, bus.mem_addr, addr);
            check({tag, "_mem_we"},   bus.mem_we,   is_d && we);
            if (is_d && we) check({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
         end
         seen = is_d ? bus.d_ready : bus.if_ready;
      end
      check({tag, "_latency"}, lat, 3 + gdly + rdly);
      bus.if_req  = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.if_kill = 1'b0;
      @(negedge clk);
      check({tag, "_ready_pulse"}, is_d ? bus.d_ready : bus.if_ready, 0);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          gdly;
      int          rdly;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [31:0] last_d;
      logic [31:0] exp;
      int d_lat, i_lat, rdy, d_cnt, i_cnt, n;

      rst         = 1'b1;
      bus.if_req  = 1'b0;
      bus.if_addr = '0;
      bus.if_kill = 1'b0;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      rv_extra    = 1'b0;
      gnt_dly     = 0;
      rv_dly      = 0;

      mem_arr[32'h10] = 32'h0050_0093;
      mem_arr[32'h14] = 32'h00A0_0113;
      mem_arr[32'h20] = 32'h1111_1111;
      mem_arr[32'h24] = 32'h02A0_0193;
      mem_arr[32'h28] = 32'h2222_2222;
      mem_arr[32'h40] = 32'hDEAD_BEEF;
      mem_arr[32'h44] = 32'h0BAD_F00D;

      vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,      0, 0, 32'h0050_0093};
      vecs[1] = '{1'b1, 1'b0, 32'h40, 32'h0,      0, 0, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, 1'b1, 32'h80, 32'h1234,   2, 2, 32'h0};
      vecs[3] = '{1'b1, 1'b0, 32'h80, 32'h0,      1, 0, 32'h0000_1234};
      vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h0,      0, 3, 32'h00A0_0113};
      vecs[5] = '{1'b1, 1'b0, 32'h44, 32'h0,      3, 1, 32'h0BAD_F00D};
      vecs[6] = '{1'b1, 1'b1, 32'h44, 32'hCAFEF00D, 0, 0, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 32'h44, 32'h0,      0, 1, 32'hCAFE_F00D};

      repeat (2) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // table-driven single transactions; a store must leave d_rdata alone
      last_d = 32'h0;
      for (int i = 0; i < 8; i++) begin
         exp = vecs[i].we ? last_d : vecs[i].exp_rdata;
         if (vecs[i].is_d && !vecs[i].we) last_d = vecs[i].exp_rdata;
         run_xact($sformatf("vec%0d", i), vecs[i].is_d, vecs[i].we, vecs[i].addr,
                  vecs[i].wdata, vecs[i].gdly, vecs[i].rdly, 0, exp);
      end

      // simultaneous fetch and load: load first, fetch issued at N+5
      gnt_dly     = 0;
      rv_dly      = 0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h40;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      sb_push(1'b1, 32'hDEAD_BEEF);
      sb_push(1'b0, 32'h0050_0093);
      d_lat = 0;
      i_lat = 0;
      for (int c = 1; c <= 20 && i_lat == 0; c++) begin
         @(negedge clk);
         if (c == 4) check("sim_mem_req_n4", bus.mem_req, 0);
         if (c == 5) begin
            check("sim_mem_req_n5",  bus.mem_req,  1);
            check("sim_mem_addr_n5", bus.mem_addr, 32'h10);
         end
         if (bus.d_ready)  begin d_lat = c; bus.d_req  = 1'b0; end
         if (bus.if_ready) begin i_lat = c; bus.if_req = 1'b0; end
      end
      check("sim_d_ready_lat",  d_lat, 3);
      check("sim_if_ready_lat", i_lat, 7);
      @(negedge clk);

      // kill in WAIT: no ready, if_rdata kept, IDLE right after RESP
      gnt_dly     = 0;
      rv_dly      = 3;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h20;
      rdy         = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 2) begin
            check("kill_busy_wait", busy, 1);
            bus.if_kill = 1'b1;
            bus.if_req  = 1'b0;
         end else begin
            bus.if_kill = 1'b0;
         end
         if (bus.if_ready) rdy++;
         if (c == 6) check("kill_busy_resp", busy, 1);
         if (c == 7) check("kill_busy_idle", busy, 0);
      end
      check("kill_no_ready",  rdy, 0);
      check("kill_if_rdata",  bus.if_rdata, 32'h0050_0093);
      run_xact("after_kill", 1'b0, 1'b0, 32'h24, 32'h0, 0, 0, 0, 32'h02A0_0193);

      // kill coincident with mem_rvalid still suppresses the ready pulse
      gnt_dly     = 0;
      rv_dly      = 1;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h28;
      rdy         = 0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 3) begin
            bus.if_kill = 1'b1;
            bus.if_req  = 1'b0;
         end else begin
            bus.if_kill = 1'b0;
         end
         if (bus.if_ready) rdy++;
         if (c == 5) check("kill_rv_busy_idle", busy, 0);
      end
      check("kill_rv_no_ready", rdy, 0);

      // kill while the data port owns the memory is ignored
      run_xact("d_kill", 1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 2, 32'hDEAD_BEEF);

      // starvation: both held high for ten transactions
      gnt_dly     = 0;
      rv_dly      = 0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 32'h40;
      bus.if_req  = 1'b1;
      bus.if_addr = 32'h10;
      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
         if (k % 5 == 4) sb_push(1'b0, 32'h0050_0093);
         else            sb_push(1'b1, 32'hDEAD_BEEF);
`else
         sb_push(1'b1, 32'hDEAD_BEEF);
`endif
      end
      n     = 0;
      d_cnt = 0;
      i_cnt = 0;
      for (int c = 1; c <= 60 && n < 10; c++) begin
         @(negedge clk);
         if (bus.d_ready)  begin d_cnt++; n++; end
         if (bus.if_ready) begin i_cnt++; n++; end
      end
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      check("starve_d_grants",  d_cnt, 8);
      check("starve_if_grants", i_cnt, 2);
`else
      check("starve_d_grants",  d_cnt, 10);
      check("starve_if_grants", i_cnt, 0);
`endif
      @(negedge clk);

      // reset pulsed mid-WAIT; a late mem_rvalid must be ignored
      gnt_dly    = 0;
      rv_dly     = 5;
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 32'h44;
      @(negedge clk);
      @(negedge clk);
      check("rst_busy_wait", busy, 1);
      rst       = 1'b1;
      bus.d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      check_outputs_zero("rst_mid");
      rv_extra = 1'b1;
      @(negedge clk);
      rv_extra = 1'b0;
      check("late_rv_busy",    busy,        0);
      check("late_rv_d_rdata", bus.d_rdata, 0);
      @(negedge clk);
      check("late_rv_busy2",   busy,        0);
      check("late_rv_d_ready", bus.d_ready, 0);

      repeat (2) @(negedge clk);
      check("sb_drained", sb_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
